// File: rtl/irq_pkg.sv
// irq_pkg: shared definitions for the interrupt sequencer.
//   - FSM state encoding (IDLE, ARMED, TAKE, HANDLER, RET)
//   - Cause ExcCode for external interrupts and the exception vector
//   - Status register bit positions for IE and the IM field
package irq_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ARMED   = 3'd1;
  localparam logic [2:0] ST_TAKE    = 3'd2;
  localparam logic [2:0] ST_HANDLER = 3'd3;
  localparam logic [2:0] ST_RET     = 3'd4;

  localparam logic [4:0]  EXC_INT  = 5'd0;
  localparam logic [31:0] VEC_ADDR = 32'h0000_0180;

  localparam int unsigned STATUS_IE_BIT  = 0;
  localparam int unsigned STATUS_IM_BASE = 8;

endpackage

// File: rtl/irq_sync_edge.sv
// irq_sync_edge: synchronizes one asynchronous interrupt line into the Clk
// domain and flags its rising edge for one cycle.
// Ports:
//   Clk     in  clock
//   Reset   in  asynchronous active-low reset
//   i_irq   in  raw asynchronous interrupt line
//   o_rise  out one-cycle pulse on a rising edge of the synchronized line
module irq_sync_edge
  import irq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic Clk,
  input  logic Reset,
  input  logic i_irq,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_irq};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign o_rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/irq_sequencer.sv
// irq_sequencer: external interrupt entry/return sequencing for the
// 5-stage pipeline. Edges on the IRQ lines latch into a pending register;
// enabled requests wait for a safe pipeline point (no stall, no branch in
// decode) and then fire a one-cycle take pulse. The handler runs until an
// eret in decode, which produces a one-cycle return pulse.
// Ports:
//   Clk, Reset    clock, asynchronous active-low reset
//   i_irq         raw interrupt lines (index 0 highest priority)
//   i_im, i_ie    Status interrupt mask bits and global enable
//   i_stall       StallF | StallD
//   i_branch_d    branch/jump in decode
//   i_eret        eret in decode
//   o_take        vector select / F-D-E flush / EPC write pulse
//   o_cause_we    Cause write enable (same as o_take)
//   o_cause_ip    one-hot serviced line, valid with o_take
//   o_exccode     Cause ExcCode, always Int
//   o_ie_clr      clears Status IE (same as o_take)
//   o_ret         eret return pulse, restores IE
//   o_in_handler  handler residency flag
//   o_pending     pending register
module irq_sequencer
  import irq_pkg::*;
#(
  parameter int unsigned N_IRQ       = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MAX_WAIT    = 15
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [N_IRQ-1:0] i_irq,
  input  logic [N_IRQ-1:0] i_im,
  input  logic             i_ie,
  input  logic             i_stall,
  input  logic             i_branch_d,
  input  logic             i_eret,
  output logic             o_take,
  output logic             o_cause_we,
  output logic [N_IRQ-1:0] o_cause_ip,
  output logic [4:0]       o_exccode,
  output logic             o_ie_clr,
  output logic             o_ret,
  output logic             o_in_handler,
  output logic [N_IRQ-1:0] o_pending
);

  localparam int unsigned    CW      = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(MAX_WAIT);

  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] pending_q, pending_d;
  logic [N_IRQ-1:0] cause_q, cause_d;
  logic [N_IRQ-1:0] en, sel, clr;
  logic             req, found, take;
  logic [2:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  for (genvar k = 0; k < N_IRQ; k++) begin : g_sync
    irq_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .Clk   (Clk),
      .Reset (Reset),
      .i_irq (i_irq[k]),
      .o_rise(rise[k])
    );
  end

  // Fixed priority: lowest enabled index wins.
  always_comb begin
    en    = pending_q & i_im;
    req   = (|en) & i_ie;
    sel   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < N_IRQ; k++) begin
      if (en[k] && !found) begin
        sel[k] = 1'b1;
        found  = 1'b1;
      end
    end
  end

  assign take = (state_q == ST_TAKE);

  // A new edge in the clearing cycle keeps the line pending.
  always_comb begin
    clr       = take ? cause_q : '0;
    pending_d = (pending_q & ~clr) | rise;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d = ST_ARMED;
          cnt_d   = '0;
        end
      end
      ST_ARMED: begin
        if (!req) begin
          state_d = ST_IDLE;
        end else if (!i_stall && !i_branch_d) begin
          state_d = ST_TAKE;
          cause_d = sel;
        end else if (!i_stall && (cnt_q == CNT_MAX)) begin
          // Waited long enough: take despite the branch in decode.
          state_d = ST_TAKE;
          cause_d = sel;
        end else if (!i_stall) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_TAKE: begin
        state_d = ST_HANDLER;
      end
      ST_HANDLER: begin
        if (i_eret && !i_stall) begin
          state_d = ST_RET;
        end
      end
      ST_RET: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      cause_q   <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cause_q   <= cause_d;
      pending_q <= pending_d;
    end
  end

  assign o_take       = take;
  assign o_cause_we   = take;
  assign o_ie_clr     = take;
  assign o_cause_ip   = take ? cause_q : '0;
  assign o_exccode    = EXC_INT;
  assign o_ret        = (state_q == ST_RET);
  assign o_in_handler = (state_q == ST_HANDLER);
  assign o_pending    = pending_q;

endmodule

// File: tb/tb_irq_sequencer.sv
module tb_irq_sequencer;

  localparam int unsigned N_IRQ = 2;

  logic             Clk;
  logic             Reset;
  logic [N_IRQ-1:0] i_irq;
  logic [N_IRQ-1:0] i_im;
  logic             i_ie;
  logic             i_stall;
  logic             i_branch_d;
  logic             i_eret;
  logic             o_take;
  logic             o_cause_we;
  logic [N_IRQ-1:0] o_cause_ip;
  logic [4:0]       o_exccode;
  logic             o_ie_clr;
  logic             o_ret;
  logic             o_in_handler;
  logic [N_IRQ-1:0] o_pending;

  int nchk = 0;
  int nerr = 0;

  irq_sequencer #(
    .N_IRQ      (N_IRQ),
    .SYNC_STAGES(2),
    .MAX_WAIT   (15)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .i_irq       (i_irq),
    .i_im        (i_im),
    .i_ie        (i_ie),
    .i_stall     (i_stall),
    .i_branch_d  (i_branch_d),
    .i_eret      (i_eret),
    .o_take      (o_take),
    .o_cause_we  (o_cause_we),
    .o_cause_ip  (o_cause_ip),
    .o_exccode   (o_exccode),
    .o_ie_clr    (o_ie_clr),
    .o_ret       (o_ret),
    .o_in_handler(o_in_handler),
    .o_pending   (o_pending)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Cycle n is the interval starting #1 after rising edge n.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_take"},   {31'd0, o_take},       32'd0);
    check({tag, "_cwe"},    {31'd0, o_cause_we},   32'd0);
    check({tag, "_ieclr"},  {31'd0, o_ie_clr},     32'd0);
    check({tag, "_ret"},    {31'd0, o_ret},        32'd0);
    check({tag, "_inh"},    {31'd0, o_in_handler}, 32'd0);
    check({tag, "_pend"},   {30'd0, o_pending},    32'd0);
    check({tag, "_ip"},     {30'd0, o_cause_ip},   32'd0);
    check({tag, "_exc"},    {27'd0, o_exccode},    32'd0);
  endtask

  task automatic check_take(input string tag, input logic [1:0] ip);
    check({tag, "_take"},  {31'd0, o_take},     32'd1);
    check({tag, "_cwe"},   {31'd0, o_cause_we}, 32'd1);
    check({tag, "_ieclr"}, {31'd0, o_ie_clr},   32'd1);
    check({tag, "_ip"},    {30'd0, o_cause_ip}, {30'd0, ip});
    check({tag, "_exc"},   {27'd0, o_exccode},  32'd0);
    check({tag, "_noret"}, {31'd0, o_ret},      32'd0);
  endtask

  // Called while in HANDLER; leaves the bench in the IDLE cycle after RET.
  task automatic do_ret(input string tag);
    i_eret = 1'b1;
    step(1);
    check({tag, "_ret"},    {31'd0, o_ret},  32'd1);
    check({tag, "_rettk"},  {31'd0, o_take}, 32'd0);
    i_eret = 1'b0;
    step(1);
    check({tag, "_retoff"}, {31'd0, o_ret},  32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    Reset = 1'b0; i_irq = '0; i_im = 2'b11; i_ie = 1'b1;
    i_stall = 1'b0; i_branch_d = 1'b0; i_eret = 1'b0;
    step(3);
    check_all_zero("rst");
    Reset = 1'b1;
    step(3);
    check_all_zero("idle");

    // Single line 0, safe pipeline: take in cycle 4.
    i_irq = 2'b01;
    step(1);
    step(3);
    check("t1_early", {31'd0, o_take}, 32'd0);
    step(1);
    check_take("t1", 2'b01);
    step(1);
    check("t1_inh",  {31'd0, o_in_handler}, 32'd1);
    check("t1_pend", {30'd0, o_pending},    32'd0);
    check("t1_tk0",  {31'd0, o_take},       32'd0);
    i_irq = 2'b00;
    do_ret("t1");
    step(3);

    // Both lines together: line 0 first, line 1 after return (RET, IDLE, ARMED, TAKE).
    i_irq = 2'b11;
    step(1);
    step(4);
    check_take("t2a", 2'b01);
    i_irq = 2'b00;
    step(1);
    check("t2_pend", {30'd0, o_pending}, 32'd2);
    do_ret("t2");
    check("t2_idle",  {31'd0, o_take}, 32'd0);
    step(1);
    check("t2_armed", {31'd0, o_take}, 32'd0);
    step(1);
    check_take("t2b", 2'b10);
    step(1);
    do_ret("t2b");
    step(3);

    // Branch in decode delays the take until it falls.
    i_branch_d = 1'b1;
    i_irq = 2'b01;
    step(1);
    step(5);
    check("t3_hold", {31'd0, o_take}, 32'd0);
    i_branch_d = 1'b0;
    step(1);
    check_take("t3", 2'b01);
    i_irq = 2'b00;
    step(1);
    do_ret("t3");
    step(3);

    // Branch stuck high: forced take after 15 counted cycles (ARMED at 3, take at 19).
    i_branch_d = 1'b1;
    i_irq = 2'b01;
    step(1);
    step(18);
    check("t4a_hold", {31'd0, o_take}, 32'd0);
    step(1);
    check_take("t4a", 2'b01);
    i_irq = 2'b00;
    step(1);
    check("t4a_inh", {31'd0, o_in_handler}, 32'd1);
    do_ret("t4a");
    step(3);

    // Same, with 5 stalled ARMED cycles freezing the counter: take at 24.
    i_irq = 2'b01;
    step(1);
    step(3);
    i_stall = 1'b1;
    step(5);
    i_stall = 1'b0;
    step(15);
    check("t4b_hold", {31'd0, o_take}, 32'd0);
    step(1);
    check_take("t4b", 2'b01);
    i_irq = 2'b00;
    i_branch_d = 1'b0;
    step(1);
    // Stall blocks the eret in HANDLER.
    i_stall = 1'b1;
    i_eret = 1'b1;
    step(1);
    check("t4b_stret", {31'd0, o_ret},        32'd0);
    check("t4b_stinh", {31'd0, o_in_handler}, 32'd1);
    i_stall = 1'b0;
    step(1);
    check("t4b_ret", {31'd0, o_ret}, 32'd1);
    i_eret = 1'b0;
    step(4);

    // Masked line stays pending until unmasked.
    i_im = 2'b01;
    i_irq = 2'b10;
    step(1);
    for (int i = 0; i < 6; i++) begin
      step(1);
      check("t5_masked", {31'd0, o_take}, 32'd0);
    end
    check("t5_pend", {30'd0, o_pending}, 32'd2);
    i_im = 2'b11;
    step(1);
    check("t5_armed", {31'd0, o_take}, 32'd0);
    step(1);
    check_take("t5", 2'b10);
    i_irq = 2'b00;
    step(1);
    do_ret("t5");
    step(3);

    // eret outside HANDLER is ignored.
    i_eret = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("t6_noret", {31'd0, o_ret}, 32'd0);
    end
    i_eret = 1'b0;
    step(3);

    // New edge during handler: no nesting, taken after the return.
    i_irq = 2'b01;
    step(1);
    step(4);
    check_take("t7a", 2'b01);
    i_irq = 2'b00;
    step(2);
    i_irq = 2'b01;
    for (int i = 0; i < 4; i++) begin
      step(1);
      check("t7_nonest", {31'd0, o_take},       32'd0);
      check("t7_inh",    {31'd0, o_in_handler}, 32'd1);
    end
    check("t7_pend", {30'd0, o_pending}, 32'd1);
    do_ret("t7");
    check("t7_idle",  {31'd0, o_take}, 32'd0);
    step(1);
    check("t7_armed", {31'd0, o_take}, 32'd0);
    step(1);
    check_take("t7b", 2'b01);
    i_irq = 2'b00;
    step(1);
    check("t7b_inh", {31'd0, o_in_handler}, 32'd1);
    step(2);

    // Asynchronous reset in HANDLER, then nothing without a fresh edge.
    Reset = 1'b0;
    #1;
    check_all_zero("t8_rst");
    step(2);
    Reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      check("t8_take", {31'd0, o_take},       32'd0);
      check("t8_ret",  {31'd0, o_ret},        32'd0);
      check("t8_inh",  {31'd0, o_in_handler}, 32'd0);
      check("t8_pend", {30'd0, o_pending},    32'd0);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
